trainer_sweep_seq: RTL and testbench

TRAINER_SWEEP_SEQ -- requirements
Module: trainer_sweep_seq

---
 rtl/trainer_pkg.sv | 35 +++
 rtl/trainer_sweep_seq_if.sv | 37 +++
 rtl/trainer_debounce.sv | 70 +++++++
 rtl/trainer_sweep_seq.sv | 161 ++++++++++++++++
 tb/tb_trainer_sweep_seq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/trainer_pkg.sv
// ---------------------------------------------------------------------------
// trainer_pkg
// Shared definitions for the logic-trainer sweep sequencer:
//   - sweep_state_t : sequencer FSM states
//   - GATE_*        : gate select encodings understood by the gate block
//   - ROW_COUNT     : number of rows in a 2-input truth table
//   - is_last_row() : true when an index addresses the final table row
// ---------------------------------------------------------------------------
package trainer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SAMPLE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } sweep_state_t;

    typedef logic [2:0] gate_sel_t;

    localparam gate_sel_t GATE_AND  = 3'b000;
    localparam gate_sel_t GATE_OR   = 3'b001;
    localparam gate_sel_t GATE_NOT  = 3'b010;
    localparam gate_sel_t GATE_NAND = 3'b011;
    localparam gate_sel_t GATE_NOR  = 3'b100;
    localparam gate_sel_t GATE_XOR  = 3'b101;
    localparam gate_sel_t GATE_XNOR = 3'b110;

    localparam int ROW_COUNT = 4;

    function automatic logic is_last_row(input logic [1:0] row);
        return row == 2'(ROW_COUNT - 1);
    endfunction

endpackage

// File: rtl/trainer_sweep_seq_if.sv
// ---------------------------------------------------------------------------
// trainer_sweep_seq_if
// Bundles the user controls and the gate-block connection of the sweep
// sequencer.
//   ena, step_btn, mode_auto, sel_in, y_in        : into the sequencer
//   a_out, b_out, sel_out, idx, truth_table,
//   table_valid                                   : out of the sequencer
// The captured table is named truth_table because "table" is a reserved
// word in SystemVerilog.
// Modports: master = sequencer side, slave = switches/gate-block side.
// ---------------------------------------------------------------------------
interface trainer_sweep_seq_if;
    import trainer_pkg::*;

    logic       ena;
    logic       step_btn;
    logic       mode_auto;
    gate_sel_t  sel_in;
    logic       y_in;
    logic       a_out;
    logic       b_out;
    gate_sel_t  sel_out;
    logic [1:0] idx;
    logic [3:0] truth_table;
    logic       table_valid;

    modport master (
        input  ena, step_btn, mode_auto, sel_in, y_in,
        output a_out, b_out, sel_out, idx, truth_table, table_valid
    );

    modport slave (
        output ena, step_btn, mode_auto, sel_in, y_in,
        input  a_out, b_out, sel_out, idx, truth_table, table_valid
    );

endinterface

// File: rtl/trainer_debounce.sv
// ---------------------------------------------------------------------------
// trainer_debounce
// Two-flop synchroniser followed by a counting debouncer for the manual
// step push-button. Emits a single-cycle pulse when the debounced level
// rises.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   ena        : freezes counter and level when low (synchroniser keeps
//                sampling)
//   btn_async  : raw, asynchronous button input
//   step_pulse : 1-cycle pulse on the debounced rising edge
// Parameter DEBOUNCE_CYCLES: consecutive differing cycles needed before the
// debounced level follows the synchronised input.
// ---------------------------------------------------------------------------
module trainer_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic btn_async,
    output logic step_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] stable_cnt;

    // The synchroniser is not gated by ena so that a stale metastable sample
    // is never presented when the block is re-enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_async;
            sync_2 <= sync_1;
        end
    end

    // Count cycles on which the synchronised input disagrees with the
    // accepted level; any agreeing cycle (a bounce) restarts the count.
    // The pulse is registered together with the level flip.
    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= 1'b0;
            stable_cnt <= '0;
            step_pulse <= 1'b0;
        end else if (!ena) begin
            step_pulse <= 1'b0;
        end else if (sync_2 != level) begin
            if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level      <= sync_2;
                stable_cnt <= '0;
                step_pulse <= sync_2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
                step_pulse <= 1'b0;
            end
        end else begin
            stable_cnt <= '0;
            step_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/trainer_sweep_seq.sv
// ---------------------------------------------------------------------------
// trainer_sweep_seq
// Walks a 2-input gate block through its four input combinations, one per
// step event, and captures the returned result into a 4-bit truth table.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, overrides everything
//   bus : trainer_sweep_seq_if.master
//         inputs  ena, step_btn, mode_auto, sel_in, y_in
//         outputs a_out, b_out, sel_out, idx, truth_table, table_valid
// Parameters:
//   DEBOUNCE_CYCLES : button debounce length
//   AUTO_DIV        : cycles between automatic step events
// Build option TRAINER_AUTO_STEP_EN: when defined, a prescaler generates a
// step event every AUTO_DIV enabled cycles while mode_auto=1 and the button
// is ignored in that mode. When undefined, mode_auto has no effect and only
// the button produces step events.
// ---------------------------------------------------------------------------
module trainer_sweep_seq
    import trainer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_DIV        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    trainer_sweep_seq_if.master  bus
);

    logic         btn_evt;
    logic         step_evt;
    sweep_state_t state;
    logic [1:0]   idx_q;
    gate_sel_t    sel_q;
    logic [3:0]   table_q;
    logic         valid_q;
    logic         sel_changed;

    trainer_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .ena        (bus.ena),
        .btn_async  (bus.step_btn),
        .step_pulse (btn_evt)
    );

`ifdef TRAINER_AUTO_STEP_EN
    localparam int PW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

    logic [PW-1:0] presc;
    logic          auto_evt;

    assign auto_evt = bus.ena && bus.mode_auto && (presc == PW'(AUTO_DIV - 1));
    assign step_evt = bus.mode_auto ? auto_evt : btn_evt;

    // Leaving auto mode always restarts the prescaler so the first automatic
    // event after re-entry comes a full AUTO_DIV cycles later.
    always_ff @(posedge clk) begin
        if (rst || !bus.mode_auto) begin
            presc <= '0;
        end else if (bus.ena) begin
            if (presc == PW'(AUTO_DIV - 1)) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end
`else
    logic           unused_mode_auto;
    localparam int  unused_auto_div = AUTO_DIV;

    assign unused_mode_auto = bus.mode_auto;
    assign step_evt         = btn_evt;
`endif

    assign sel_changed = (bus.sel_in != sel_q);

    // Sweep FSM. Step events arriving in APPLY or SAMPLE are simply not
    // looked at, so they are dropped rather than queued. A select change
    // during an active sweep abandons it; in DONE the table is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            table_q <= '0;
            valid_q <= 1'b0;
        end else if (bus.ena) begin
            case (state)
                IDLE: begin
                    if (step_evt) begin
                        sel_q   <= bus.sel_in;
                        idx_q   <= '0;
                        table_q <= '0;
                        state   <= APPLY;
                    end
                end
                APPLY: begin
                    if (sel_changed) begin
                        table_q <= '0;
                        idx_q   <= '0;
                        state   <= IDLE;
                    end else begin
                        state   <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (sel_changed) begin
                        table_q <= '0;
                        idx_q   <= '0;
                        state   <= IDLE;
                    end else begin
                        table_q[idx_q] <= bus.y_in;
                        if (is_last_row(idx_q)) begin
                            valid_q <= 1'b1;
                            state   <= DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (sel_changed) begin
                        table_q <= '0;
                        idx_q   <= '0;
                        state   <= IDLE;
                    end else if (step_evt) begin
                        state   <= APPLY;
                    end
                end
                DONE: begin
                    if (step_evt) begin
                        table_q <= '0;
                        idx_q   <= '0;
                        sel_q   <= bus.sel_in;
                        valid_q <= 1'b0;
                        state   <= APPLY;
                    end
                end
                default: begin
                    table_q <= '0;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_out       = idx_q[0];
    assign bus.b_out       = idx_q[1];
    assign bus.idx         = idx_q;
    assign bus.sel_out     = sel_q;
    assign bus.truth_table = table_q;
    assign bus.table_valid = valid_q;

endmodule

// File: tb/tb_trainer_sweep_seq.sv
// ---------------------------------------------------------------------------
// tb_trainer_sweep_seq
// Self-checking bench for trainer_sweep_seq. A behavioural gate model
// answers y_in from sel_out/a_out/b_out. Every sweep expected to complete
// pushes its predicted truth table into a queue; a monitor pops and compares
// on each rising edge of table_valid.
// ---------------------------------------------------------------------------
module tb_trainer_sweep_seq;
    import trainer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   assertCount = 0;
    int   failCount   = 0;
    int   cycleCount  = 0;
    logic [3:0] sbQueue[$];
    logic validPrev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    trainer_sweep_seq_if bus ();

    trainer_sweep_seq #(
        .DEBOUNCE_CYCLES (4),
        .AUTO_DIV        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Independent gate model: AND OR NOT(a) NAND NOR XOR XNOR
    function automatic logic gateModel(input logic [2:0] sel, input logic a, input logic b);
        case (sel)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return ~a;
            3'b011:  return ~(a & b);
            3'b100:  return ~(a | b);
            3'b101:  return a ^ b;
            3'b110:  return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] expectedTable(input logic [2:0] sel);
        logic [3:0] t;
        logic [1:0] k;
        t = '0;
        for (int i = 0; i < 4; i++) begin
            k    = 2'(i);
            t[i] = gateModel(sel, k[0], k[1]);
        end
        return t;
    endfunction

    assign bus.y_in = gateModel(bus.sel_out, bus.a_out, bus.b_out);

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic btn, input int cycles);
        bus.step_btn = btn;
        waitCycles(cycles);
    endtask

    task automatic pressButton();
        applyStimulus(1'b1, 8);
        applyStimulus(1'b0, 8);
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_idx"},   32'(bus.idx),         32'd0);
        checkOutput({pfx, "_a"},     32'(bus.a_out),       32'd0);
        checkOutput({pfx, "_b"},     32'(bus.b_out),       32'd0);
        checkOutput({pfx, "_sel"},   32'(bus.sel_out),     32'd0);
        checkOutput({pfx, "_table"}, 32'(bus.truth_table), 32'd0);
        checkOutput({pfx, "_valid"}, 32'(bus.table_valid), 32'd0);
    endtask

    // Scoreboard monitor: a completed table must have been predicted.
    always @(negedge clk) begin
        if (bus.table_valid && !validPrev) begin
            checkOutput("sb_pending", 32'(sbQueue.size() > 0), 32'd1);
            if (sbQueue.size() > 0) begin
                checkOutput("sb_table", 32'(bus.truth_table), 32'(sbQueue.pop_front()));
            end
        end
        validPrev <= bus.table_valid;
    end

    initial begin
        rst           = 1'b1;
        bus.ena       = 1'b1;
        bus.step_btn  = 1'b0;
        bus.mode_auto = 1'b0;
        bus.sel_in    = 3'b101;
        waitCycles(3);
        rst = 1'b0;
        checkResetValues("reset");

        // Bouncing button: never stable for 4 cycles, so no event
        bus.sel_in = 3'b110;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2);
            applyStimulus(1'b0, 2);
        end
        waitCycles(8);
        checkOutput("bounce_idx", 32'(bus.idx),     32'd0);
        checkOutput("bounce_sel", 32'(bus.sel_out), 32'd0);

        // Six stable high cycles: exactly one event starts an AND sweep
        bus.sel_in = 3'b000;
        sbQueue.push_back(expectedTable(3'b000));
        applyStimulus(1'b1, 6);
        applyStimulus(1'b0, 10);
        checkOutput("single_event_idx", 32'(bus.idx), 32'd1);
        repeat (3) pressButton();
        checkOutput("and_table", 32'(bus.truth_table), 32'h8);
        checkOutput("and_valid", 32'(bus.table_valid), 32'd1);
        checkOutput("done_ab",   32'({bus.b_out, bus.a_out}), 32'd3);

        // Select change in DONE does not disturb the held table
        bus.sel_in = 3'b001;
        waitCycles(4);
        checkOutput("done_hold_table", 32'(bus.truth_table), 32'h8);
        checkOutput("done_hold_valid", 32'(bus.table_valid), 32'd1);

        // OR sweep with an ena=0 window in WAIT at idx=2
        sbQueue.push_back(expectedTable(3'b001));
        pressButton();
        checkOutput("or_restart_valid", 32'(bus.table_valid), 32'd0);
        checkOutput("or_restart_sel",   32'(bus.sel_out),     32'd1);
        pressButton();
        checkOutput("or_partial_idx",   32'(bus.idx),         32'd2);
        checkOutput("or_partial_table", 32'(bus.truth_table), 32'h2);
        bus.ena = 1'b0;
        applyStimulus(1'b1, 6);
        applyStimulus(1'b0, 4);
        checkOutput("ena_hold_idx",   32'(bus.idx),         32'd2);
        checkOutput("ena_hold_table", 32'(bus.truth_table), 32'h2);
        bus.ena = 1'b1;
        waitCycles(10);
        checkOutput("resume_idx", 32'(bus.idx), 32'd2);
        repeat (2) pressButton();
        checkOutput("or_table", 32'(bus.truth_table), 32'hE);
        checkOutput("or_valid", 32'(bus.table_valid), 32'd1);

        // NAND sweep aborted by a select change in WAIT at idx=2
        bus.sel_in = 3'b011;
        repeat (2) pressButton();
        checkOutput("pre_abort_idx",   32'(bus.idx),         32'd2);
        checkOutput("pre_abort_table", 32'(bus.truth_table), 32'h3);
        bus.sel_in = 3'b001;
        waitCycles(1);
        checkOutput("abort_idx",   32'(bus.idx),         32'd0);
        checkOutput("abort_table", 32'(bus.truth_table), 32'h0);
        checkOutput("abort_valid", 32'(bus.table_valid), 32'd0);

        // Reset asserted while in SAMPLE of row 1 (event at edge 6 of the
        // press, APPLY after edge 7, SAMPLE after edge 8)
        bus.sel_in = 3'b011;
        pressButton();
        checkOutput("pre_rst_table0", 32'(bus.truth_table), 32'h1);
        applyStimulus(1'b1, 6);
        applyStimulus(1'b0, 2);
        checkOutput("sample_idx",   32'(bus.idx),         32'd1);
        checkOutput("sample_table", 32'(bus.truth_table), 32'h1);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkResetValues("midrst");
        waitCycles(8);

`ifdef TRAINER_AUTO_STEP_EN
        begin
            int         times[$];
            logic [1:0] lastIdx;
            bus.sel_in    = 3'b101;
            sbQueue.push_back(expectedTable(3'b101));
            lastIdx       = bus.idx;
            bus.mode_auto = 1'b1;
            for (int c = 0; c < 200 && times.size() < 4; c++) begin
                waitCycles(1);
                if (bus.idx != lastIdx || (bus.table_valid && times.size() == 3)) begin
                    times.push_back(cycleCount);
                    lastIdx = bus.idx;
                end
            end
            bus.mode_auto = 1'b0;
            checkOutput("auto_steps_seen", 32'(times.size()), 32'd4);
            if (times.size() == 4) begin
                for (int i = 1; i < 4; i++) begin
                    checkOutput("auto_spacing", 32'(times[i] - times[i-1]), 32'd16);
                end
            end
            checkOutput("auto_xor_table", 32'(bus.truth_table), 32'h6);
        end
`endif

        waitCycles(5);
        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
